// File: rtl/jtframe_pdm_decim.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : jtframe_pdm_decim
//  Description : Third-order CIC decimator turning a 1-bit PDM stream into
//                16-bit PCM samples with a one-cycle valid strobe. The output
//                format matches the sigma-delta DAC input convention.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtframe_pdm_decim #(
  parameter int   LOG2D      = 6,
  parameter int   CEN_DIV    = 4,
  parameter logic SIGNED_SND = 1'b0
) (
  input  logic        clk_dac,
  input  logic        rst,
  input  logic        pdm_in,
  output logic [15:0] pcm,
  output logic        pcm_valid,
  output logic        cen_pdm
);

  localparam int               W           = 3*LOG2D + 1;
  localparam int               FS          = 3*LOG2D;
  localparam logic [3:0]       CEN_LAST    = 4'(CEN_DIV - 1);
  localparam logic [LOG2D-1:0] DCNT_LAST   = {LOG2D{1'b1}};
  localparam logic [LOG2D-1:0] DCNT_ONE    = {{(LOG2D-1){1'b0}}, 1'b1};
  localparam logic [15:0]      PCM_SILENCE = {~SIGNED_SND, 15'h0000};

  logic             s1_q, s1_d, s2_q, s2_d;
  logic [3:0]       ccnt_q, ccnt_d;
  logic [LOG2D-1:0] dcnt_q, dcnt_d;
  logic [W-1:0]     i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic [W-1:0]     cap_q, cap_d;
  logic [3:0]       vsr_q, vsr_d;
  logic             live_q, live_d;
  logic [1:0]       warm_q, warm_d;
  logic [W-1:0]     c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
  logic [W-1:0]     d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic [15:0]      pcm_q, pcm_d;
  logic             pcm_valid_q, pcm_valid_d;

  logic             evt;
  logic [15:0]      u;
  logic             unused_c3_lsbs;

  // Bit-rate enable and decimation event detection.
  always_comb begin
    cen_pdm = (ccnt_q == CEN_LAST);
    ccnt_d  = cen_pdm ? 4'd0 : ccnt_q + 4'd1;
    evt     = cen_pdm && (dcnt_q == DCNT_LAST);
  end

  // Synchronizer, integrator chain (old values feed the next stage), capture.
  always_comb begin
    s1_d   = pdm_in;
    s2_d   = s1_q;
    i1_d   = i1_q;
    i2_d   = i2_q;
    i3_d   = i3_q;
    dcnt_d = dcnt_q;
    cap_d  = cap_q;
    live_d = live_q;
    warm_d = warm_q;
    if (cen_pdm) begin
      i1_d   = i1_q + {{(W-1){1'b0}}, s2_q};
      i2_d   = i2_q + i1_q;
      i3_d   = i3_q + i2_q;
      dcnt_d = dcnt_q + DCNT_ONE;
    end
    if (evt) begin
      cap_d  = i3_q;
      // Sample is published only once the combs hold three real history words.
      live_d = (warm_q == 2'd3);
      if (warm_q != 2'd3) warm_d = warm_q + 2'd1;
    end
  end

  // Comb pipeline: each stage fires one cycle after the previous one.
  always_comb begin
    vsr_d = {vsr_q[2:0], evt};
    c1_d  = c1_q;
    d1_d  = d1_q;
    c2_d  = c2_q;
    d2_d  = d2_q;
    c3_d  = c3_q;
    d3_d  = d3_q;
    if (vsr_q[0]) begin
      c1_d = cap_q - d1_q;
      d1_d = cap_q;
    end
    if (vsr_q[1]) begin
      c2_d = c1_q - d2_q;
      d2_d = c1_q;
    end
    if (vsr_q[2]) begin
      c3_d = c2_q - d3_q;
      d3_d = c2_q;
    end
  end

  // Scale to 16 bits (full scale clamps to all ones) and apply output format.
  always_comb begin
    u              = c3_q[W-1] ? 16'hFFFF : c3_q[FS-1 -: 16];
    unused_c3_lsbs = ^c3_q;
    pcm_valid_d    = vsr_q[3] & live_q;
    pcm_d          = pcm_q;
    if (vsr_q[3] && live_q) pcm_d = {u[15] ^ SIGNED_SND, u[14:0]};
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk_dac or posedge rst) begin
    if (rst) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      ccnt_q      <= 4'd0;
      dcnt_q      <= '0;
      i1_q        <= '0;
      i2_q        <= '0;
      i3_q        <= '0;
      cap_q       <= '0;
      vsr_q       <= 4'd0;
      live_q      <= 1'b0;
      warm_q      <= 2'd0;
      c1_q        <= '0;
      c2_q        <= '0;
      c3_q        <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      d3_q        <= '0;
      pcm_q       <= PCM_SILENCE;
      pcm_valid_q <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      ccnt_q      <= ccnt_d;
      dcnt_q      <= dcnt_d;
      i1_q        <= i1_d;
      i2_q        <= i2_d;
      i3_q        <= i3_d;
      cap_q       <= cap_d;
      vsr_q       <= vsr_d;
      live_q      <= live_d;
      warm_q      <= warm_d;
      c1_q        <= c1_d;
      c2_q        <= c2_d;
      c3_q        <= c3_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      d3_q        <= d3_d;
      pcm_q       <= pcm_d;
      pcm_valid_q <= pcm_valid_d;
    end
  end

  assign pcm       = pcm_q;
  assign pcm_valid = pcm_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_jtframe_pdm_decim.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_jtframe_pdm_decim
//  Description : Self-checking bench for jtframe_pdm_decim. Two instances
//                (CEN_DIV=4 offset binary, CEN_DIV=5 two's complement) share
//                one PDM stream; expected samples come from the CIC impulse
//                response (three cascaded boxcars) applied to the recorded
//                input history.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jtframe_pdm_decim;

  localparam int LOG2D = 6;
  localparam int R     = 1 << LOG2D;
  localparam int NT    = 3*R - 2;

  logic        clk_dac = 1'b0;
  logic        rst     = 1'b1;
  logic        pdm_in  = 1'b0;
  logic [15:0] pcm_o   [2];
  logic        valid_o [2];
  logic        cen_o   [2];

  jtframe_pdm_decim #(.LOG2D(LOG2D), .CEN_DIV(4), .SIGNED_SND(1'b0)) u_dut_a (
    .clk_dac   (clk_dac),
    .rst       (rst),
    .pdm_in    (pdm_in),
    .pcm       (pcm_o[0]),
    .pcm_valid (valid_o[0]),
    .cen_pdm   (cen_o[0])
  );

  jtframe_pdm_decim #(.LOG2D(LOG2D), .CEN_DIV(5), .SIGNED_SND(1'b1)) u_dut_b (
    .clk_dac   (clk_dac),
    .rst       (rst),
    .pdm_in    (pdm_in),
    .pcm       (pcm_o[1]),
    .pcm_valid (valid_o[1]),
    .cen_pdm   (cen_o[1])
  );

  always #5 clk_dac = ~clk_dac;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          cdv [2] = '{4, 5};
  logic        sgn [2] = '{1'b0, 1'b1};
  logic [15:0] sil [2] = '{16'h8000, 16'h0000};

  int          h [NT];
  bit          hist [$];
  int          k;
  logic [15:0] exp_pcm   [2];
  logic        exp_valid [2];
  logic [15:0] pend      [2];
  int          due       [2];

  // Impulse response of three cascaded length-R boxcars.
  function automatic void build_h();
    int b2 [2*R-1];
    for (int i = 0; i < 2*R-1; i++) b2[i] = 0;
    for (int i = 0; i < NT; i++) h[i] = 0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < R; j++) b2[i+j] += 1;
    for (int i = 0; i < 2*R-1; i++)
      for (int j = 0; j < R; j++) h[i+j] += b2[i];
  endfunction

  // Bit seen by the filter at its j-th bit-rate enable (two-flop sync delay).
  function automatic int b_at(int d, int j);
    int idx;
    if (j < 1) return 0;
    idx = j*cdv[d] - 2;
    if (idx < 1) return 0;
    return int'(hist[idx-1]);
  endfunction

  // Decimated sample n: filter output, clamp/truncate to 16 bits, format.
  function automatic logic [15:0] expect_sample(int d, int n);
    longint      acc = 0;
    logic [15:0] u;
    for (int t = 0; t < NT; t++) acc += longint'(h[t] * b_at(d, n*R - 3 - t));
    if (acc >= (longint'(1) << (3*LOG2D))) u = 16'hFFFF;
    else                                   u = 16'(acc >> (3*LOG2D - 16));
    return sgn[d] ? (u ^ 16'h8000) : u;
  endfunction

  task automatic reset_model();
    hist.delete();
    k = 0;
    for (int d = 0; d < 2; d++) begin
      exp_pcm[d]   = sil[d];
      exp_valid[d] = 1'b0;
      due[d]       = -1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk_dac);
      pdm_in = 1'($urandom);
    end
    @(negedge clk_dac);
    rst = 1'b0;
    reset_model();
  endtask

  // One clock: record input, advance the reference, then drive the next bit.
  task automatic tick(input logic nxt);
    int n;
    @(posedge clk_dac);
    #1;
    hist.push_back(pdm_in);
    k++;
    for (int d = 0; d < 2; d++) begin
      exp_valid[d] = 1'b0;
      if (due[d] == k) begin
        exp_valid[d] = 1'b1;
        exp_pcm[d]   = pend[d];
        due[d]       = -1;
      end
      if (k % (R*cdv[d]) == 0) begin
        n = k / (R*cdv[d]);
        if (n >= 4) begin
          pend[d] = expect_sample(d, n);
          due[d]  = k + 4;
        end
      end
    end
    pdm_in = nxt;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk_dac);
    #1;
    reset_model();
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (pcm_o[d] !== sil[d]) begin
        n_fail++; $display("FAIL reset_pcm dut%0d got %h expected %h", d, pcm_o[d], sil[d]);
      end
      n_chk++;
      if (valid_o[d] !== 1'b0) begin
        n_fail++; $display("FAIL reset_valid dut%0d got %b expected 0", d, valid_o[d]);
      end
      n_chk++;
      if (cen_o[d] !== 1'b0) begin
        n_fail++; $display("FAIL reset_cen dut%0d got %b expected 0", d, cen_o[d]);
      end
    end
    @(negedge clk_dac);
    rst = 1'b0;
    reset_model();
    for (int c = 0; c < 12; c++) begin
      tick(1'b0);
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (cen_o[d] !== ((k % cdv[d]) == cdv[d]-1)) begin
          n_fail++; $display("FAIL cen_start dut%0d k=%0d got %b", d, k, cen_o[d]);
        end
      end
    end
  endtask

  task automatic test_all_ones();
    int last_a = -1;
    int strobes_a = 0;
    do_reset();
    pdm_in = 1'b1;
    for (int c = 0; c < 8*R*4 + 8; c++) begin
      tick(1'b1);
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (cen_o[d] !== ((k % cdv[d]) == cdv[d]-1)) begin
          n_fail++; $display("FAIL ones_cen dut%0d k=%0d got %b", d, k, cen_o[d]);
        end
        n_chk++;
        if (valid_o[d] !== exp_valid[d]) begin
          n_fail++; $display("FAIL ones_valid dut%0d k=%0d got %b expected %b", d, k, valid_o[d], exp_valid[d]);
        end
        n_chk++;
        if (pcm_o[d] !== exp_pcm[d]) begin
          n_fail++; $display("FAIL ones_pcm dut%0d k=%0d got %h expected %h", d, k, pcm_o[d], exp_pcm[d]);
        end
      end
      if (valid_o[0] === 1'b1) begin
        strobes_a++;
        n_chk++;
        if (pcm_o[0] !== 16'hFFFF) begin
          n_fail++; $display("FAIL ones_fullscale k=%0d got %h expected ffff", k, pcm_o[0]);
        end
        if (last_a >= 0) begin
          n_chk++;
          if (k - last_a != 256) begin
            n_fail++; $display("FAIL ones_period got %0d expected 256", k - last_a);
          end
        end
        last_a = k;
      end
    end
    n_chk++;
    if (strobes_a != 5) begin
      n_fail++; $display("FAIL ones_strobe_count got %0d expected 5", strobes_a);
    end
  endtask

  task automatic test_all_zeros();
    do_reset();
    pdm_in = 1'b0;
    for (int c = 0; c < 6*R*5 + 8; c++) begin
      tick(1'b0);
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (valid_o[d] !== exp_valid[d]) begin
          n_fail++; $display("FAIL zeros_valid dut%0d k=%0d got %b expected %b", d, k, valid_o[d], exp_valid[d]);
        end
        n_chk++;
        if (pcm_o[d] !== exp_pcm[d]) begin
          n_fail++; $display("FAIL zeros_pcm dut%0d k=%0d got %h expected %h", d, k, pcm_o[d], exp_pcm[d]);
        end
        if (valid_o[d] === 1'b1) begin
          n_chk++;
          if (pcm_o[d] !== (sgn[d] ? 16'h8000 : 16'h0000)) begin
            n_fail++; $display("FAIL zeros_level dut%0d got %h", d, pcm_o[d]);
          end
        end
      end
    end
  endtask

  task automatic test_alternating();
    int diff;
    do_reset();
    for (int c = 0; c < 7*R*5 + 8; c++) begin
      tick(((k/4) % 2) == 1);
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (valid_o[d] !== exp_valid[d]) begin
          n_fail++; $display("FAIL alt_valid dut%0d k=%0d got %b expected %b", d, k, valid_o[d], exp_valid[d]);
        end
        n_chk++;
        if (pcm_o[d] !== exp_pcm[d]) begin
          n_fail++; $display("FAIL alt_pcm dut%0d k=%0d got %h expected %h", d, k, pcm_o[d], exp_pcm[d]);
        end
      end
      if (valid_o[0] === 1'b1) begin
        diff = int'(pcm_o[0]) - 32'h8000;
        n_chk++;
        if (diff > 1 || diff < -1) begin
          n_fail++; $display("FAIL alt_midscale got %h expected 8000 +-1", pcm_o[0]);
        end
      end
    end
  endtask

  task automatic test_random();
    int dens;
    do_reset();
    dens = 50;
    for (int c = 0; c < 10*R*4 + 8; c++) begin
      if (k % 256 == 0) dens = int'($urandom_range(0, 100));
      tick($urandom_range(0, 99) < dens);
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (cen_o[d] !== ((k % cdv[d]) == cdv[d]-1)) begin
          n_fail++; $display("FAIL rnd_cen dut%0d k=%0d got %b", d, k, cen_o[d]);
        end
        n_chk++;
        if (valid_o[d] !== exp_valid[d]) begin
          n_fail++; $display("FAIL rnd_valid dut%0d k=%0d got %b expected %b", d, k, valid_o[d], exp_valid[d]);
        end
        n_chk++;
        if (pcm_o[d] !== exp_pcm[d]) begin
          n_fail++; $display("FAIL rnd_pcm dut%0d k=%0d got %h expected %h", d, k, pcm_o[d], exp_pcm[d]);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    int first_b = -1;
    do_reset();
    while (k < 6*256 + 100) tick(1'($urandom));
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (pcm_o[d] !== sil[d] || valid_o[d] !== 1'b0) begin
        n_fail++; $display("FAIL mid_async dut%0d got %h/%b expected %h/0", d, pcm_o[d], valid_o[d], sil[d]);
      end
    end
    repeat (3) begin
      @(posedge clk_dac);
      #1;
      pdm_in = 1'($urandom);
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (pcm_o[d] !== sil[d] || valid_o[d] !== 1'b0) begin
          n_fail++; $display("FAIL mid_hold dut%0d got %h/%b expected %h/0", d, pcm_o[d], valid_o[d], sil[d]);
        end
      end
    end
    @(negedge clk_dac);
    rst = 1'b0;
    reset_model();
    for (int c = 0; c < 5*R*5 + 8; c++) begin
      tick(1'($urandom));
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (valid_o[d] !== exp_valid[d]) begin
          n_fail++; $display("FAIL mid_valid dut%0d k=%0d got %b expected %b", d, k, valid_o[d], exp_valid[d]);
        end
        n_chk++;
        if (pcm_o[d] !== exp_pcm[d]) begin
          n_fail++; $display("FAIL mid_pcm dut%0d k=%0d got %h expected %h", d, k, pcm_o[d], exp_pcm[d]);
        end
      end
      if (valid_o[1] === 1'b1 && first_b < 0) first_b = k;
    end
    n_chk++;
    if (first_b != 4*R*5 + 4) begin
      n_fail++; $display("FAIL mid_first_strobe got %0d expected %0d", first_b, 4*R*5 + 4);
    end
  endtask

  initial begin
    build_h();
    test_reset();
    test_all_ones();
    test_all_zeros();
    test_alternating();
    test_random();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
